// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // 2-of-3 vote used by the majority-sampling build.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Metastability synchroniser: SYNC_STAGES flops, reset to 1 (line idle level).
module uart_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk_i) begin
    if (reset_i) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver with single-entry holding register and sticky error flags.
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 majority sampling, needs CLKS_PER_BIT >= 8).
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 215,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      overrun,
  output logic                      frame_err,
  input  logic                      err_clr,
  output logic                      busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(UART_DATA_BITS - 1);

  logic rxs;
  logic line;   // level used for start/break detection
  logic samp;   // value taken at each bit decision point

  uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (rxd),
    .q_o     (rxs)
  );

`ifdef UART_RX_MAJORITY_EN
  // The FSM runs on rxs delayed one clock, so at the target count the
  // window {hist_q[1], hist_q[0], rxs} spans target-1..target+1.
  logic [1:0] hist_q;

  // Two-deep history of the synchronised line.
  always_ff @(posedge clk) begin
    if (reset) hist_q <= '1;
    else       hist_q <= {hist_q[0], rxs};
  end

  assign line = hist_q[0];
  assign samp = maj3(hist_q[1], hist_q[0], rxs);
`else
  assign line = rxs;
  assign samp = rxs;
`endif

  uart_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      brk_q, brk_d;
  logic                      done_q, done_d;
  logic                      ferr_set;

  logic [UART_DATA_BITS-1:0] rx_data_q;
  logic                      rx_valid_q, overrun_q, frame_err_q;
  logic                      consume, ovr_set;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state, bit counter, shift register and frame-event decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    brk_d    = brk_q;
    done_d   = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (brk_q) begin
          if (line) brk_d = 1'b0;
        end else if (!line) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = samp ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {samp, shreg_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (samp) begin
            done_d = 1'b1;
          end else begin
            ferr_set = 1'b1;
            brk_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Receive datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      brk_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      brk_q   <= brk_d;
      done_q  <= done_d;
    end
  end

  // Handshake and overrun decode for the holding register.
  always_comb begin
    consume = rx_valid_q & rx_ready;
    ovr_set = done_q & rx_valid_q & ~consume;
  end

  // Holding register and sticky flags; a new error outranks err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (done_q && (!rx_valid_q || consume)) begin
        rx_data_q  <= shreg_q;
        rx_valid_q <= 1'b1;
      end else if (consume) begin
        rx_valid_q <= 1'b0;
      end
      overrun_q   <= ovr_set  | (overrun_q   & ~err_clr);
      frame_err_q <= ferr_set | (frame_err_q & ~err_clr);
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser with an expected-byte scoreboard queue.
`timescale 1ns/1ps
module tb_uart_rx_deser;

  localparam int unsigned CPB  = 215;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned SYNC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, overrun, frame_err, busy;

  uart_rx_deser #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .overrun   (overrun),
    .frame_err (frame_err),
    .err_clr   (err_clr),
    .busy      (busy)
  );

  always #50 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  exp_q[$];
  int unsigned fall_cyc = 0;
  int unsigned rise_cyc = 0;
  logic        prev_valid = 1'b0;

  // Record the cycle at which rx_valid rises.
  always @(negedge clk) begin
    if (rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    fall_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (!rx_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, rx_valid, 1'b1);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      check(tag, rx_data, e);
    end
  endtask

  task automatic consume();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] t2_bytes [4];
    t2_bytes = '{8'h35, 8'h37, 8'h38, 8'h0A};

    // Reset state
    idle(5);
    check("rst_data",  rx_data,   8'h00);
    check("rst_valid", rx_valid,  1'b0);
    check("rst_ovr",   overrun,   1'b0);
    check("rst_ferr",  frame_err, 1'b0);
    check("rst_busy",  busy,      1'b0);
    reset = 1'b0;
    idle(10);

    // T1: single byte, latency and data
    exp_q.push_back(8'h35);
    send_frame(8'h35, 1'b1);
    check("t1_latency", rise_cyc - fall_cyc, SYNC + HALF + 9 * CPB + 2);
    check("t1_valid", rx_valid, 1'b1);
    pop_check("t1_data");
    check("t1_ovr",  overrun,   1'b0);
    check("t1_ferr", frame_err, 1'b0);
    check("t1_busy", busy,      1'b0);
    consume();
    check("t1_valid_clr", rx_valid, 1'b0);
    check("t1_data_hold", rx_data,  8'h35);

    // T2: four bytes, each consumed promptly
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(t2_bytes[k]);
      fork
        send_frame(t2_bytes[k], 1'b1);
        begin
          wait_valid("t2_wait", 2300);
          pop_check("t2_data");
          idle(3);
          consume();
        end
      join
      idle(150);
    end
    check("t2_ovr", overrun, 1'b0);
    check("t2_sb_drained", exp_q.size(), 0);

    // T3: overrun with consumer stalled, then err_clr
    exp_q.push_back(8'h31);
    send_frame(8'h31, 1'b1);
    send_frame(8'h34, 1'b1);
    check("t3_valid", rx_valid, 1'b1);
    pop_check("t3_data");
    check("t3_ovr", overrun, 1'b1);
    pulse_err_clr();
    check("t3_ovr_clr", overrun, 1'b0);
    check("t3_data_kept", rx_data, 8'h31);
    consume();
    check("t3_valid_clr", rx_valid, 1'b0);

    // T4: 50-clock glitch rejected
    idle(20);
    @(negedge clk);
    rxd = 1'b0;
    fall_cyc = cyc;
    idle(50);
    rxd = 1'b1;
    idle(55);
    check("t4_busy_mid", busy, 1'b1);
    idle(10);
    check("t4_busy_drop", busy,      1'b0);
    check("t4_valid",     rx_valid,  1'b0);
    check("t4_ferr",      frame_err, 1'b0);
    check("t4_ovr",       overrun,   1'b0);

    // T5: framing error, then recovery
    idle(20);
    send_frame(8'h55, 1'b0);
    check("t5_ferr",  frame_err, 1'b1);
    check("t5_valid", rx_valid,  1'b0);
    check("t5_ovr",   overrun,   1'b0);
    idle(20);
    exp_q.push_back(8'h0A);
    send_frame(8'h0A, 1'b1);
    check("t5_valid2", rx_valid, 1'b1);
    pop_check("t5_data2");
    check("t5_ferr_sticky", frame_err, 1'b1);

    // T6: reset during bit 4 (holding register full, frame_err set)
    fork
      send_frame(8'hA5, 1'b1);
      begin
        idle(1 + 5 * CPB + 100);
        check("t6_busy_pre", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_data",  rx_data,   8'h00);
        check("t6_valid", rx_valid,  1'b0);
        check("t6_ovr",   overrun,   1'b0);
        check("t6_ferr",  frame_err, 1'b0);
        check("t6_busy",  busy,      1'b0);
      end
    join
    reset = 1'b0;
    idle(20);
    exp_q.push_back(8'h38);
    send_frame(8'h38, 1'b1);
    check("t6_valid2", rx_valid, 1'b1);
    pop_check("t6_data2");
    check("t6_ovr2",  overrun,   1'b0);
    check("t6_ferr2", frame_err, 1'b0);
    consume();
    check("t6_valid_clr", rx_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
